// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, one-entry holding
// register on a valid/ready output and single-cycle error pulses.
//
// Ports:
//   clk           : sole clock
//   rst_n         : asynchronous active-low reset
//   urx_pin       : serial line, idles high
//   urx_valid     : received byte available
//   urx_data[7:0] : received byte, stable while urx_valid is high
//   urx_ready     : consumer accepts on urx_valid && urx_ready
//   urx_frame_err : one-cycle pulse, stop bit sampled low
//   urx_overrun   : one-cycle pulse, completed byte dropped
//
// Optional macro UART_RX_SYNC_EN: route urx_pin through a 2-flop
// synchronizer (reset to 1) before the FSM; all events move 2 cycles later.
module uart_rx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       urx_pin,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       urx_frame_err,
    output logic       urx_overrun
);

    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], urx_pin};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = urx_pin;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Each state counts down from its reload value and acts when the
    // counter reaches zero; the reload happens on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    cnt_d   = HALF;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = DATA;
                    cnt_d   = FULL;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sh_d  = {rx, sh_q[7:1]};
                    cnt_d = FULL;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done_d  = 1'b1;
                    ferr_d  = !rx;
                    state_d = rx ? IDLE : BRK;
                    cnt_d   = '0;
                end
            end
            BRK: begin
                if (rx) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register. done_q/ferr_q are the stop-sample result, so all
    // output events land on the edge after the stop sample. sh_q is not
    // touched again until the next frame's data bits, so it is still
    // the completed byte here.
    logic good;
    assign good = done_q && !ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            urx_valid     <= 1'b0;
            urx_data      <= 8'h00;
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;
        end else begin
            urx_frame_err <= done_q && ferr_q;
            urx_overrun   <= good && urx_valid && !urx_ready;
            if (good && (!urx_valid || urx_ready)) begin
                urx_data  <= sh_q;
                urx_valid <= 1'b1;
            end else if (urx_valid && urx_ready) begin
                urx_valid <= 1'b0;
            end
        end
    end

endmodule
